pipe_ctrl: RTL and testbench

Central pipeline controller for the MINA2000 five-stage core. It sequences the inter-stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) by generating per-stage enable and valid/bubble signals. It resolves three events:
- load-use hazards between EX and ID;
- taken branches resolved in EX, including fetch-latency shadow flushing;
- data-memory wait states.

It also keeps wrapping performance counters for stall and flush activity.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_ctrl_hazard_detect.sv | 31 +++
 rtl/pipe_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller.
// State encoding and stage-register control bundle.
package pipe_ctrl_pkg;

  localparam int SHADOW_W = 3;

  typedef enum logic [1:0] {
    PS_RUN,
    PS_MEM_WAIT,
    PS_FLUSH
  } pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic id_ex_valid;
    logic ex_mem_en;
    logic mem_wb_valid;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection between EX and ID.
// Register 0 is hardwired and never hazards.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_id_valid,
  input  logic                  i_id_uses_ra,
  input  logic                  i_id_uses_rb,
  input  logic [REG_ADDR_W-1:0] i_id_ra_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rb_addr,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_is_load,
  input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
  output logic                  o_load_use
);

  logic w_ra_hit;
  logic w_rb_hit;
  logic w_rd_nz;

  assign w_rd_nz  = (i_ex_rd_addr != '0);
  assign w_ra_hit = i_id_uses_ra
                  & (i_id_ra_addr == i_ex_rd_addr);
  assign w_rb_hit = i_id_uses_rb
                  & (i_id_rb_addr == i_ex_rd_addr);

  assign o_load_use = i_ex_valid & i_ex_is_load
                    & i_id_valid & w_rd_nz
                    & (w_ra_hit | w_rb_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage enables, bubbles,
// redirect shadow flushing and perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FETCH_LAT  = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_uses_ra,
  input  logic                  id_uses_rb,
  input  logic [REG_ADDR_W-1:0] id_ra_addr,
  input  logic [REG_ADDR_W-1:0] id_rb_addr,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_valid,
  output logic                  ex_mem_en,
  output logic                  mem_wb_valid,
  output logic                  busy,
  output logic [CNT_W-1:0]      perf_stall_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt
);

  localparam logic [SHADOW_W-1:0] SH_INIT =
    SHADOW_W'(FETCH_LAT - 1);

  pipe_state_t         r_state;
  pipe_state_t         r_ret;
  logic [SHADOW_W-1:0] r_shadow;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  pipe_state_t         w_eff;
  pipe_state_t         w_nstate;
  pipe_state_t         w_nret;
  logic [SHADOW_W-1:0] w_nshadow;
  pipe_ctrl_t          w_ctrl;
  logic                w_flush;
  logic                w_stall_inc;
  logic                w_flush_inc;
  logic                w_mem_stall;
  logic                w_redirect;
  logic                w_load_use;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hz (
    .i_id_valid  (id_valid),
    .i_id_uses_ra(id_uses_ra),
    .i_id_uses_rb(id_uses_rb),
    .i_id_ra_addr(id_ra_addr),
    .i_id_rb_addr(id_rb_addr),
    .i_ex_valid  (ex_valid),
    .i_ex_is_load(ex_is_load),
    .i_ex_rd_addr(ex_rd_addr),
    .o_load_use  (w_load_use)
  );

  assign w_mem_stall = mem_req & ~mem_ready;
  assign w_redirect  = ex_valid & ex_branch_taken;

  // MEM_WAIT resumes whatever state preceded it.
  assign w_eff = (r_state == PS_MEM_WAIT)
               ? r_ret : r_state;

  // Priority resolution of events and next state.
  always_comb begin
    w_ctrl      = '1;
    w_flush     = 1'b0;
    w_nstate    = r_state;
    w_nret      = r_ret;
    w_nshadow   = r_shadow;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (rst) begin
      w_ctrl.id_ex_valid  = 1'b0;
      w_ctrl.mem_wb_valid = 1'b0;
      w_flush             = 1'b1;
    end else begin
      priority case (1'b1)
        w_mem_stall: begin
          w_ctrl.pc_en        = 1'b0;
          w_ctrl.if_id_en     = 1'b0;
          w_ctrl.id_ex_en     = 1'b0;
          w_ctrl.ex_mem_en    = 1'b0;
          w_ctrl.mem_wb_valid = 1'b0;
          w_stall_inc         = 1'b1;
          w_nstate            = PS_MEM_WAIT;
          w_nret              = w_eff;
        end
        w_redirect: begin
          w_flush            = 1'b1;
          w_ctrl.id_ex_valid = 1'b0;
          w_flush_inc        = 1'b1;
          w_nshadow          = SH_INIT;
          w_nstate = (SH_INIT == '0)
                   ? PS_RUN : PS_FLUSH;
        end
        w_load_use: begin
          w_ctrl.pc_en       = 1'b0;
          w_ctrl.if_id_en    = 1'b0;
          w_ctrl.id_ex_valid = 1'b0;
          w_stall_inc        = 1'b1;
          w_nstate           = w_eff;
        end
        default: begin
          w_nstate = w_eff;
          if (w_eff == PS_FLUSH) begin
            w_flush   = 1'b1;
            w_nshadow = r_shadow - 1'b1;
            if (r_shadow <= 1) begin
              w_nstate  = PS_RUN;
              w_nshadow = '0;
            end
          end
        end
      endcase
    end
  end

  // State, shadow and wrapping counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PS_RUN;
      r_ret       <= PS_RUN;
      r_shadow    <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state  <= w_nstate;
      r_ret    <= w_nret;
      r_shadow <= w_nshadow;
      if (w_stall_inc)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign pc_en          = w_ctrl.pc_en;
  assign if_id_en       = w_ctrl.if_id_en;
  assign if_id_flush    = w_flush;
  assign id_ex_en       = w_ctrl.id_ex_en;
  assign id_ex_valid    = w_ctrl.id_ex_valid;
  assign ex_mem_en      = w_ctrl.ex_mem_en;
  assign mem_wb_valid   = w_ctrl.mem_wb_valid;
  assign busy           = (r_state != PS_RUN);
  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl.
// FETCH_LAT=3, CNT_W=4.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_ra, id_uses_rb;
  logic [4:0] id_ra_addr, id_rb_addr;
  logic       ex_valid, ex_is_load;
  logic [4:0] ex_rd_addr;
  logic       ex_branch_taken;
  logic       mem_req, mem_ready;
  logic       pc_en, if_id_en, if_id_flush;
  logic       id_ex_en, id_ex_valid;
  logic       ex_mem_en, mem_wb_valid, busy;
  logic [3:0] perf_stall_cnt, perf_flush_cnt;
  logic [7:0] outs;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [7:0] O_RUN  = 8'b1101_1110;
  localparam logic [7:0] O_RST  = 8'b1111_0100;
  localparam logic [7:0] O_LU   = 8'b0001_0110;
  localparam logic [7:0] O_BR   = 8'b1111_0110;
  localparam logic [7:0] O_FL   = 8'b1111_1111;
  localparam logic [7:0] O_MW0  = 8'b0000_1000;
  localparam logic [7:0] O_MW   = 8'b0000_1001;
  localparam logic [7:0] O_BRMW = 8'b1111_0111;

  pipe_ctrl #(
    .REG_ADDR_W(5),
    .FETCH_LAT (3),
    .CNT_W     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_uses_ra     (id_uses_ra),
    .id_uses_rb     (id_uses_rb),
    .id_ra_addr     (id_ra_addr),
    .id_rb_addr     (id_rb_addr),
    .ex_valid       (ex_valid),
    .ex_is_load     (ex_is_load),
    .ex_rd_addr     (ex_rd_addr),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_en       (id_ex_en),
    .id_ex_valid    (id_ex_valid),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_valid   (mem_wb_valid),
    .busy           (busy),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {pc_en, if_id_en, if_id_flush,
                 id_ex_en, id_ex_valid, ex_mem_en,
                 mem_wb_valid, busy};

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_uses_ra = 0; id_uses_rb = 0;
    id_ra_addr = 0; id_rb_addr = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd_addr = 0;
    ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd,
                        input logic ua,
                        input logic [4:0] ra,
                        input logic ub,
                        input logic [4:0] rb);
    idle();
    id_valid = 1; ex_valid = 1; ex_is_load = 1;
    ex_rd_addr = rd;
    id_uses_ra = ua; id_ra_addr = ra;
    id_uses_rb = ub; id_rb_addr = rb;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    chk("rst_outs", outs, O_RST);
    chk("rst_stall", {4'd0, perf_stall_cnt}, 8'd0);
    chk("rst_flush", {4'd0, perf_flush_cnt}, 8'd0);
    cyc();
    rst = 1'b0;
    settle();
    chk("run_idle", outs, O_RUN);
    cyc();

    set_lu(5'd3, 1'b0, 5'd0, 1'b1, 5'd3);
    settle();
    chk("lu_r3_rb", outs, O_LU);
    cyc();
    chk("lu_cnt", {4'd0, perf_stall_cnt}, 8'd1);
    idle();
    settle();
    chk("lu_after", outs, O_RUN);
    cyc();

    set_lu(5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    settle();
    chk("lu_r0", outs, O_RUN);
    cyc();
    set_lu(5'd3, 1'b1, 5'd4, 1'b0, 5'd3);
    settle();
    chk("lu_nomatch", outs, O_RUN);
    cyc();
    chk("lu_cnt_hold", {4'd0, perf_stall_cnt}, 8'd1);

    idle();
    ex_valid = 1; ex_branch_taken = 1;
    settle();
    chk("br_c1", outs, O_BR);
    cyc();
    chk("br_fcnt", {4'd0, perf_flush_cnt}, 8'd1);
    idle();
    settle();
    chk("br_c2", outs, O_FL);
    cyc();
    chk("br_c3", outs, O_FL);
    cyc();
    chk("br_done", outs, O_RUN);
    cyc();
    chk("br_fcnt2", {4'd0, perf_flush_cnt}, 8'd1);

    ex_valid = 1; ex_branch_taken = 1;
    cyc();
    idle();
    settle();
    chk("fl_busy", outs, O_FL);
    rst = 1'b1;
    settle();
    chk("fl_rst_outs", outs, O_RST);
    chk("fl_rst_stall", {4'd0, perf_stall_cnt}, 8'd0);
    chk("fl_rst_flush", {4'd0, perf_flush_cnt}, 8'd0);
    cyc();
    rst = 1'b0;
    settle();
    chk("post_rst1", outs, O_RUN);
    cyc();
    chk("post_rst2", outs, O_RUN);
    cyc();

    idle();
    ex_valid = 1; ex_branch_taken = 1;
    mem_req = 1; mem_ready = 0;
    settle();
    chk("mw_c1", outs, O_MW0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("mw_frz", outs, O_MW);
      cyc();
    end
    chk("mw_scnt", {4'd0, perf_stall_cnt}, 8'd4);
    chk("mw_fcnt0", {4'd0, perf_flush_cnt}, 8'd0);
    mem_ready = 1;
    settle();
    chk("mw_redir", outs, O_BRMW);
    cyc();
    chk("mw_fcnt", {4'd0, perf_flush_cnt}, 8'd1);
    chk("mw_scnt2", {4'd0, perf_stall_cnt}, 8'd4);
    idle();
    settle();
    chk("mw_fl1", outs, O_FL);
    cyc();
    chk("mw_fl2", outs, O_FL);
    cyc();
    chk("mw_run", outs, O_RUN);
    cyc();

    mem_req = 1; mem_ready = 1;
    settle();
    chk("mem_zero", outs, O_RUN);
    cyc();
    chk("mem_zero_c", {4'd0, perf_stall_cnt}, 8'd4);

    set_lu(5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
    ex_branch_taken = 1;
    settle();
    chk("br_over_lu", outs, O_BR);
    cyc();
    chk("br_lu_scnt", {4'd0, perf_stall_cnt}, 8'd4);
    idle();
    cyc();
    cyc();

    do_reset();
    settle();
    for (int i = 0; i < 17; i++) begin
      set_lu(5'd9, 1'b1, 5'd9, 1'b1, 5'd2);
      settle();
      chk("wrap_lu", outs, O_LU);
      cyc();
      idle();
      cyc();
    end
    chk("wrap_cnt", {4'd0, perf_stall_cnt}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
